// File: rtl/hcu_pkg.sv
// rtl/hcu_pkg.sv - shared constants for the hazard control unit
// Contents: operand-use times, scoreboard stage indices, default MD latencies.
package hcu_pkg;

   // Tuse values: operand consumed in ID (branch compare) or in EX (ALU).
   localparam int TUSE_B = 0;
   localparam int TUSE_C = 1;

   // Scoreboard entry indices; 0 is reserved for "register file".
   localparam int ST_RF  = 0;
   localparam int ST_EX  = 1;
   localparam int ST_MEM = 2;
   localparam int ST_WB  = 3;

   localparam int REG_W       = 5;
   localparam int MD_LAT_DEF  = 5;
   localparam int DIV_LAT_DEF = 10;

endpackage

// File: rtl/hcu_src_check.sv
// rtl/hcu_src_check.sv - youngest-match hazard/forward check for one source operand
// Ports:
//   valid            ID holds a real instruction
//   src, tuse        source register number and its use time
//   a3_flat          scoreboard destinations, entry k at [(k-1)*REG_W +: REG_W]
//   tnew_flat        scoreboard Tnew values, entry k at [(k-1)*TNEW_W +: TNEW_W]
//   hazard           operand not ready in time
//   fwd              entry index supplying the operand, 0 = register file
module hcu_src_check
   import hcu_pkg::*;
#(
   parameter int NSTAGE = ST_WB,
   parameter int TNEW_W = 2,
   parameter int FW     = $clog2(NSTAGE + 1)
)
(
   input  logic                       valid,
   input  logic [REG_W-1:0]           src,
   input  logic [TNEW_W-1:0]          tuse,
   input  logic [NSTAGE*REG_W-1:0]    a3_flat,
   input  logic [NSTAGE*TNEW_W-1:0]   tnew_flat,
   output logic                       hazard,
   output logic [FW-1:0]              fwd
);

   logic              hit;
   logic              active;
   logic [TNEW_W-1:0] hit_tnew;
   logic [FW-1:0]     hit_k;

   always_comb begin
      hit      = 1'b0;
      hit_tnew = '0;
      hit_k    = '0;
      // Scan oldest to youngest so the youngest match is the one left standing.
      for (int k = NSTAGE; k >= 1; k--) begin
         if (a3_flat[(k-1)*REG_W +: REG_W] == src) begin
            hit      = 1'b1;
            hit_tnew = tnew_flat[(k-1)*TNEW_W +: TNEW_W];
            hit_k    = FW'(k);
         end
      end
      // Register 0 is never a real dependency; empty entries also carry a3=0.
      active = valid && (src != '0) && hit;
      hazard = active && (hit_tnew > tuse);
      fwd    = (active && (hit_tnew == '0)) ? hit_k : '0;
   end

endmodule

// File: rtl/hcu_scoreboard.sv
// rtl/hcu_scoreboard.sv - scoreboard-based hazard control unit beside the ID stage
// Optional feature macro: HCU_MD_EN (multiply/divide busy counter and HI/LO hazard).
// Ports:
//   clk, reset                    rising-edge clock, async active-high reset
//   mem_stall_MEM                 memory backpressure, freezes the whole pipeline
//   id_valid                      ID holds a real instruction
//   A1_ID/A2_ID, Tuse_rs/Tuse_rt  source registers and their use times
//   A3_ID, Tnew_ID                destination register and its result latency
//   md_start_ID, md_is_div        ID instruction starts mult/div, and it is div
//   md_use_ID                     ID instruction touches HI/LO or the MD unit
//   stall, flush_EX               freeze PC+IF/ID, insert bubble into ID/EX
//   fwd_rs, fwd_rt                forwarding source entry, 0 = register file
//   md_busy                       MD unit busy
module hcu_scoreboard
   import hcu_pkg::*;
#(
   parameter int NSTAGE  = ST_WB,
   parameter int TNEW_W  = 2,
   parameter int MD_LAT  = MD_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF,
   parameter int FW      = $clog2(NSTAGE + 1)
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_stall_MEM,
   input  logic              id_valid,
   input  logic [4:0]        A1_ID,
   input  logic [4:0]        A2_ID,
   input  logic [TNEW_W-1:0] Tuse_rs,
   input  logic [TNEW_W-1:0] Tuse_rt,
   input  logic [4:0]        A3_ID,
   input  logic [TNEW_W-1:0] Tnew_ID,
   input  logic              md_start_ID,
   input  logic              md_is_div,
   input  logic              md_use_ID,
   output logic              stall,
   output logic              flush_EX,
   output logic [FW-1:0]     fwd_rs,
   output logic [FW-1:0]     fwd_rt,
   output logic              md_busy
);

   logic [NSTAGE*REG_W-1:0]  a3_q,   a3_d;
   logic [NSTAGE*TNEW_W-1:0] tnew_q, tnew_d;
   logic                     hazard_rs, hazard_rt, md_hazard;
   logic                     issue;

   function automatic logic [TNEW_W-1:0] dec_sat0(input logic [TNEW_W-1:0] v);
      return (v == '0) ? '0 : v - 1'b1;
   endfunction

   hcu_src_check #(.NSTAGE(NSTAGE), .TNEW_W(TNEW_W), .FW(FW)) u_rs (
      .valid     (id_valid),
      .src       (A1_ID),
      .tuse      (Tuse_rs),
      .a3_flat   (a3_q),
      .tnew_flat (tnew_q),
      .hazard    (hazard_rs),
      .fwd       (fwd_rs)
   );

   hcu_src_check #(.NSTAGE(NSTAGE), .TNEW_W(TNEW_W), .FW(FW)) u_rt (
      .valid     (id_valid),
      .src       (A2_ID),
      .tuse      (Tuse_rt),
      .a3_flat   (a3_q),
      .tnew_flat (tnew_q),
      .hazard    (hazard_rt),
      .fwd       (fwd_rt)
   );

   assign stall    = hazard_rs | hazard_rt | md_hazard | mem_stall_MEM;
   assign flush_EX = stall & ~mem_stall_MEM;
   // stall covers mem_stall_MEM, so issue already implies the pipeline advances.
   assign issue    = id_valid & ~stall;

   always_comb begin
      a3_d                 = '0;
      tnew_d               = '0;
      a3_d[REG_W-1:0]      = issue ? A3_ID   : '0;
      tnew_d[TNEW_W-1:0]   = issue ? Tnew_ID : '0;
      for (int k = 2; k <= NSTAGE; k++) begin
         a3_d[(k-1)*REG_W +: REG_W]    = a3_q[(k-2)*REG_W +: REG_W];
         tnew_d[(k-1)*TNEW_W +: TNEW_W] = dec_sat0(tnew_q[(k-2)*TNEW_W +: TNEW_W]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a3_q   <= '0;
         tnew_q <= '0;
      end else if (!mem_stall_MEM) begin
         a3_q   <= a3_d;
         tnew_q <= tnew_d;
      end
   end

`ifdef HCU_MD_EN
   localparam int MD_MAX = (DIV_LAT > MD_LAT) ? DIV_LAT : MD_LAT;
   localparam int MD_CW  = $clog2(MD_MAX + 1);

   logic [MD_CW-1:0] md_cnt;

   // The counter keeps running under memory backpressure; a fresh issue beats expiry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         md_cnt <= '0;
      end else if (issue && md_start_ID) begin
         md_cnt <= md_is_div ? MD_CW'(DIV_LAT) : MD_CW'(MD_LAT);
      end else if (md_cnt != '0) begin
         md_cnt <= md_cnt - 1'b1;
      end
   end

   assign md_busy   = (md_cnt != '0);
   assign md_hazard = md_use_ID & id_valid & md_busy;
`else
   logic md_unused;
   assign md_unused = &{1'b0, md_start_ID, md_is_div, md_use_ID};
   assign md_busy   = 1'b0;
   assign md_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_hcu_scoreboard.sv
// tb/tb_hcu_scoreboard.sv - self-checking bench for hcu_scoreboard
module tb_hcu_scoreboard;
   import hcu_pkg::*;

   localparam int NSTAGE  = 3;
   localparam int TNEW_W  = 2;
   localparam int MD_LAT  = 5;
   localparam int DIV_LAT = 10;
   localparam int FW      = 2;
`ifdef HCU_MD_EN
   localparam bit MD_ON = 1'b1;
`else
   localparam bit MD_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              mem_stall_MEM, id_valid, md_start_ID, md_is_div, md_use_ID;
   logic [4:0]        A1_ID, A2_ID, A3_ID;
   logic [TNEW_W-1:0] Tuse_rs, Tuse_rt, Tnew_ID;
   logic              stall, flush_EX, md_busy;
   logic [FW-1:0]     fwd_rs, fwd_rt;

   hcu_scoreboard #(.NSTAGE(NSTAGE), .TNEW_W(TNEW_W), .MD_LAT(MD_LAT),
                    .DIV_LAT(DIV_LAT), .FW(FW)) dut (
      .clk(clk), .reset(reset), .mem_stall_MEM(mem_stall_MEM), .id_valid(id_valid),
      .A1_ID(A1_ID), .A2_ID(A2_ID), .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt),
      .A3_ID(A3_ID), .Tnew_ID(Tnew_ID), .md_start_ID(md_start_ID),
      .md_is_div(md_is_div), .md_use_ID(md_use_ID), .stall(stall),
      .flush_EX(flush_EX), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: list of in-flight instructions, index 0 = EX.
   // Remaining latency is derived from the original Tnew and how far it has travelled.
   typedef struct { int a3; int tnew0; } ent_t;
   ent_t pipe[$];
   int   cyc, md_issue, md_lat;
   logic          e_stall, e_flush, e_busy;
   logic [FW-1:0] e_fwd_rs, e_fwd_rt;

   function automatic void src_model(input int s, input int tuse, output int haz, output int fwd);
      haz = 0;
      fwd = 0;
      if (id_valid && s != 0) begin
         for (int i = 0; i < pipe.size(); i++) begin
            if (pipe[i].a3 == s) begin
               int t;
               t   = pipe[i].tnew0 - i;
               if (t < 0) t = 0;
               haz = (t > tuse) ? 1 : 0;
               fwd = (t == 0) ? i + 1 : 0;
               break;
            end
         end
      end
   endfunction

   task automatic model_eval();
      int hr, fr, ht, ft, mh;
      src_model(int'(A1_ID), int'(Tuse_rs), hr, fr);
      src_model(int'(A2_ID), int'(Tuse_rt), ht, ft);
      e_busy = (md_issue >= 0) && (cyc - md_issue < md_lat);
      mh     = (MD_ON && id_valid && md_use_ID && e_busy) ? 1 : 0;
      e_stall  = (hr != 0) || (ht != 0) || (mh != 0) || mem_stall_MEM;
      e_flush  = e_stall && !mem_stall_MEM;
      e_fwd_rs = FW'(fr);
      e_fwd_rt = FW'(ft);
   endtask

   task automatic model_reset();
      ent_t z;
      z.a3 = 0;
      z.tnew0 = 0;
      pipe.delete();
      for (int i = 0; i < NSTAGE; i++) pipe.push_back(z);
      cyc = 0;
      md_issue = -1;
      md_lat = 0;
   endtask

   task automatic drive(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [1:0] tr, input logic [1:0] tt, input logic [4:0] a3,
                        input logic [1:0] tn, input logic mds, input logic mdd,
                        input logic mdu, input logic ms);
      id_valid = v; A1_ID = a1; A2_ID = a2; Tuse_rs = tr; Tuse_rt = tt;
      A3_ID = a3; Tnew_ID = tn; md_start_ID = mds; md_is_div = mdd;
      md_use_ID = mdu; mem_stall_MEM = ms;
      #1;
      model_eval();
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (!mem_stall_MEM) begin
         ent_t e;
         e.a3    = (id_valid && !e_stall) ? int'(A3_ID) : 0;
         e.tnew0 = (id_valid && !e_stall) ? int'(Tnew_ID) : 0;
         pipe.push_front(e);
         if (pipe.size() > NSTAGE) void'(pipe.pop_back());
         if (MD_ON && id_valid && !e_stall && md_start_ID) begin
            md_issue = cyc;
            md_lat   = md_is_div ? DIV_LAT : MD_LAT;
         end
      end
      @(negedge clk);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      for (int ms = 0; ms < 2; ms++) begin
         drive(1, 5'd8, 5'd9, 2'd0, 2'd0, 5'd10, 2'd2, 1, 0, 1, ms[0]);
         checks++;
         if (stall !== ms[0]) begin failures++; $display("FAIL reset_stall got=%0b want=%0b", stall, ms[0]); end
         checks++;
         if (flush_EX !== 1'b0 || md_busy !== 1'b0 || fwd_rs !== 0 || fwd_rt !== 0) begin
            failures++;
            $display("FAIL reset_outs got flush=%0b busy=%0b fwd=%0d/%0d want 0/0/0/0", flush_EX, md_busy, fwd_rs, fwd_rt);
         end
      end
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Issue a producer, then hold a consumer in ID until it stops stalling; return stall count.
   task automatic run_dep(input logic [1:0] ptnew, input logic [1:0] ctuse, input string tag,
                          output int n_stall);
      n_stall = 0;
      drive(1, 0, 0, 3, 3, 5'd8, ptnew, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1, 5'd8, 5'd8, ctuse, ctuse, 5'd9, 2'd1, 0, 0, 0, 0);
         checks++;
         if (flush_EX !== stall) begin failures++; $display("FAIL %s_flush got=%0b want=%0b", tag, flush_EX, stall); end
         if (stall !== 1'b1) break;
         n_stall++;
         tick();
      end
   endtask

   task automatic test_load_use();
      int n;
      run_dep(2'd2, TUSE_C[1:0], "lu", n);
      checks++;
      if (n != 1) begin failures++; $display("FAIL lu_stalls got=%0d want=1", n); end
      checks++;
      if (fwd_rs !== e_fwd_rs || fwd_rt !== e_fwd_rt) begin
         failures++; $display("FAIL lu_fwd got=%0d/%0d want=%0d/%0d", fwd_rs, fwd_rt, e_fwd_rs, e_fwd_rt);
      end
      apply_reset();
   endtask

   task automatic test_alu_beq();
      int n;
      run_dep(2'd1, TUSE_B[1:0], "ab", n);
      checks++;
      if (n != 1) begin failures++; $display("FAIL ab_stalls got=%0d want=1", n); end
      checks++;
      if (fwd_rs !== 2'd2) begin failures++; $display("FAIL ab_fwd got=%0d want=2", fwd_rs); end
      apply_reset();
   endtask

   task automatic test_load_beq();
      int n;
      run_dep(2'd2, TUSE_B[1:0], "lb", n);
      checks++;
      if (n != 2) begin failures++; $display("FAIL lb_stalls got=%0d want=2", n); end
      checks++;
      if (fwd_rs !== 2'd3) begin failures++; $display("FAIL lb_fwd got=%0d want=3", fwd_rs); end
      apply_reset();
   endtask

   task automatic test_youngest();
      drive(1, 0, 0, 3, 3, 5'd8, 2'd2, 0, 0, 0, 0);   // lw $8
      tick();
      drive(1, 0, 0, 3, 3, 5'd8, 2'd0, 0, 0, 0, 0);   // $8 rewritten, ready immediately
      tick();
      drive(1, 5'd8, 5'd8, 2'd0, 2'd1, 5'd10, 2'd1, 0, 0, 0, 0);
      checks++;
      if (stall !== 1'b0) begin failures++; $display("FAIL yw_stall got=%0b want=0", stall); end
      checks++;
      if (fwd_rs !== 2'd1 || fwd_rt !== 2'd1) begin
         failures++; $display("FAIL yw_fwd got=%0d/%0d want=1/1", fwd_rs, fwd_rt);
      end
      apply_reset();
   endtask

   task automatic test_md();
      int n;
      n = 0;
      drive(1, 0, 0, 3, 3, 0, 0, 1, 0, 1, 0);           // mult
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (md_busy !== MD_ON) begin failures++; $display("FAIL md_busy got=%0b want=%0b", md_busy, MD_ON); end
      tick();
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 0, 3, 3, 5'd9, 2'd1, 0, 0, 1, 0);  // mflo
         if (!stall) break;
         n++;
         tick();
      end
      checks++;
      if (n != (MD_ON ? 4 : 0)) begin failures++; $display("FAIL md_stalls got=%0d want=%0d", n, MD_ON ? 4 : 0); end
      tick();
      drive(1, 0, 0, 3, 3, 0, 0, 1, 1, 1, 0);           // div
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      checks++;
      if (md_busy !== MD_ON) begin failures++; $display("FAIL div_busy got=%0b want=%0b", md_busy, MD_ON); end
      reset = 1'b1;
      #1;
      checks++;
      if (md_busy !== 1'b0) begin failures++; $display("FAIL div_reset got=%0b want=0", md_busy); end
      apply_reset();
   endtask

   task automatic test_mem_stall();
      int n;
      n = 0;
      drive(1, 0, 0, 3, 3, 5'd8, 2'd2, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 5'd8, 5'd0, 2'd1, 2'd1, 5'd9, 2'd1, 0, 0, 0, 1);
         checks++;
         if (stall !== 1'b1 || flush_EX !== 1'b0) begin
            failures++; $display("FAIL ms_frozen got=%0b/%0b want=1/0", stall, flush_EX);
         end
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         drive(1, 5'd8, 5'd0, 2'd1, 2'd1, 5'd9, 2'd1, 0, 0, 0, 0);
         if (!flush_EX) break;
         n++;
         tick();
      end
      checks++;
      if (n != 1) begin failures++; $display("FAIL ms_after got=%0d want=1", n); end
      apply_reset();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic mds;
         mds = ($urandom_range(0, 5) == 0);
         drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), mds, 1'($urandom_range(0, 1)),
               mds | ($urandom_range(0, 3) == 0), $urandom_range(0, 4) == 0);
         checks++;
         if (stall !== e_stall || flush_EX !== e_flush || fwd_rs !== e_fwd_rs ||
             fwd_rt !== e_fwd_rt || md_busy !== e_busy) begin
            failures++;
            $display("FAIL rnd_%0d got st=%0b fl=%0b rs=%0d rt=%0d bz=%0b want st=%0b fl=%0b rs=%0d rt=%0d bz=%0b",
                     i, stall, flush_EX, fwd_rs, fwd_rt, md_busy, e_stall, e_flush, e_fwd_rs, e_fwd_rt, e_busy);
         end
         tick();
      end
   endtask

   initial begin
      reset = 1'b1;
      model_reset();
      test_reset();
      apply_reset();
      test_load_use();
      test_alu_beq();
      test_load_beq();
      test_youngest();
      test_md();
      test_mem_stall();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule
